// File: rtl/digit_scan_driver_pkg.sv
// Shared constants, types and helpers for the six-digit 7-segment scan driver.
// Segment codes are active-low and ordered {g,f,e,d,c,b,a}.
package digit_scan_driver_pkg;

  localparam int NUM_DIGITS = 6;
  localparam logic [NUM_DIGITS-1:0] COLON_DIGITS = 6'b010100;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [3:0] bcd_t;
  typedef logic [2:0] digit_sel_t;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } seg_out_t;

  // Selects one BCD nibble; unused select codes (6, 7) return 0.
  function automatic bcd_t pick_digit(input logic [4*NUM_DIGITS-1:0] digits,
                                      input digit_sel_t sel);
    bcd_t d;
    d = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (sel == digit_sel_t'(k)) d = digits[4*k +: 4];
    end
    return d;
  endfunction

endpackage

// File: rtl/digit_scan_if.sv
// Bundle between the refresh/time logic and the scan driver, plus the pin-side outputs.
// The master drives digit data and scan select; the slave (the driver) returns the pins.
interface digit_scan_if #(parameter int AN_W = 8);
  import digit_scan_driver_pkg::*;

  digit_sel_t             count;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]  blink_mask;
  logic                   blink_tick;
  logic                   colon_en;
  logic [AN_W-1:0]        an;
  logic [6:0]             seg;
  logic                   dp;

  modport master (
    output count, digits, blink_mask, blink_tick, colon_en,
    input  an, seg, dp
  );

  modport slave (
    input  count, digits, blink_mask, blink_tick, colon_en,
    output an, seg, dp
  );

endinterface

// File: rtl/digit_scan_driver_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; values above 9 show a dash.
module bcd_to_seg7
  import digit_scan_driver_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  // NOTE: a default branch gives seg a value on every path, so no latch is inferred.
  always_comb begin
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/digit_scan_driver.sv
// Scan driver for a six-digit multiplexed 7-segment display: digit mux, decode,
// anti-ghosting anode blanking on each scan change, blink and colon dots, registered pins.
module digit_scan_driver
  import digit_scan_driver_pkg::*;
#(
  parameter int BLANK_CYCLES = 4,
  parameter bit LZ_SUPPRESS  = 1'b1,
  parameter int AN_W         = 8
)(
  input  logic        clk,
  input  logic        rst,
  digit_scan_if.slave bus
);

  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0]   BLANK_LOAD = (BLANK_CYCLES > 0) ? BW'(BLANK_CYCLES - 1) : '0;
  localparam logic [AN_W-1:0] AN_OFF     = '1;

  digit_sel_t      count_q;
  logic            chg_q;
  logic [BW-1:0]   blank_cnt, blank_d;
  logic            blink_phase;
  logic [AN_W-1:0] an_q, an_d, an_sel;
  seg_out_t        out_q, out_d;

  bcd_t       digit;
  logic [6:0] seg_code;
  logic [7:0] blink_ext, colon_ext;
  logic       valid, blink_off, lz_off;

  bcd_to_seg7 u_dec (
    .bcd (digit),
    .seg (seg_code)
  );

  // Segment/dot path: everything is derived from registered count_q so pins never
  // see a combinational path from the scan input.
  always_comb begin
    blink_ext = {2'b00, bus.blink_mask};
    colon_ext = {2'b00, COLON_DIGITS};
    valid     = (count_q < digit_sel_t'(NUM_DIGITS));
    digit     = pick_digit(bus.digits, count_q);
    blink_off = valid && !blink_phase && blink_ext[count_q];
    lz_off    = LZ_SUPPRESS && (count_q == digit_sel_t'(NUM_DIGITS - 1)) && (digit == 4'd0);

    out_d.seg = seg_code;
    out_d.dp  = 1'b1;
    if (!valid || blink_off || lz_off) out_d.seg = SEG_BLANK;
    if (bus.colon_en && valid && colon_ext[count_q] && !blink_off) out_d.dp = 1'b0;
  end

  // Anode path: a change seen last cycle opens the blank window; the selected anode
  // is driven only once the window has drained.
  always_comb begin
    an_sel  = valid ? ~(AN_W'(1) << count_q) : AN_OFF;
    an_d    = an_sel;
    blank_d = blank_cnt;
    if (chg_q) begin
      blank_d = BLANK_LOAD;
      an_d    = (BLANK_CYCLES == 0) ? an_sel : AN_OFF;
    end else if (blank_cnt != '0) begin
      blank_d = blank_cnt - BW'(1);
      an_d    = AN_OFF;
    end
  end

  // NOTE: every state flop has an async reset value here, and all are updated with
  // non-blocking assignments so each reads its neighbours' pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      chg_q       <= 1'b0;
      blank_cnt   <= '0;
      blink_phase <= 1'b1;
      an_q        <= AN_OFF;
      out_q       <= '{seg: SEG_BLANK, dp: 1'b1};
    end else begin
      count_q   <= bus.count;
      chg_q     <= (bus.count != count_q);
      blank_cnt <= blank_d;
      an_q      <= an_d;
      out_q     <= out_d;
      if (bus.blink_tick) blink_phase <= ~blink_phase;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = out_q.seg;
  assign bus.dp  = out_q.dp;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Randomized and directed bench for digit_scan_driver against a timestamp-based reference model.
module tb_digit_scan_driver;

  localparam int BLANK = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  digit_scan_if #(.AN_W(8)) bus ();

  digit_scan_driver #(.BLANK_CYCLES(BLANK), .LZ_SUPPRESS(1'b1), .AN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: anode timing from the edge index of the last scan change.
  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  int         edge_n;
  int         last_chg;
  int         m_cq;
  logic       m_phase;
  logic [7:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  task automatic model_reset();
    edge_n   = 0;
    last_chg = -1000;
    m_cq     = 0;
    m_phase  = 1'b1;
    exp_an   = 8'hFF;
    exp_seg  = 7'h7F;
    exp_dp   = 1'b1;
  endtask

  task automatic model_edge();
    int  d;
    bit  valid, blanked;
    edge_n++;
    valid   = (m_cq < 6);
    d       = valid ? int'((bus.digits >> (4 * m_cq)) & 24'hF) : 0;
    blanked = valid && !m_phase && bus.blink_mask[valid ? m_cq : 0];
    exp_seg = (!valid || blanked || (m_cq == 5 && d == 0)) ? 7'h7F : segtab[d];
    exp_dp  = (bus.colon_en && (m_cq == 2 || m_cq == 4) && !blanked) ? 1'b0 : 1'b1;
    exp_an  = (valid && edge_n >= last_chg + 1 + BLANK) ? ~(8'h01 << m_cq) : 8'hFF;
    if (int'(bus.count) != m_cq) last_chg = edge_n;
    m_cq = int'(bus.count);
    if (bus.blink_tick) m_phase = ~m_phase;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("an", bus.an, exp_an);
    check("seg", bus.seg, exp_seg);
    check("dp", bus.dp, exp_dp);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    model_reset();
    bus.count      = 3'd0;
    bus.digits     = 24'h123456;
    bus.blink_mask = 6'b0;
    bus.blink_tick = 1'b0;
    bus.colon_en   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_an", bus.an, 8'hFF);
    check("rst_seg", bus.seg, 7'h7F);
    check("rst_dp", bus.dp, 1'b1);
    rst = 1'b0;

    ticks(5);
    check("release_an_fe", bus.an, 8'hFE);

    // Single change: anode low on the fifth edge after the change edge.
    bus.count = 3'd1;
    ticks(5);
    check("step01_blank", bus.an, 8'hFF);
    tick();
    check("step01_an", bus.an, 8'hFD);
    check("step01_seg5", bus.seg, 7'h12);

    // Change during blanking restarts the window.
    bus.count = 3'd2;
    ticks(2);
    bus.count = 3'd3;
    ticks(5);
    check("restart_blank", bus.an, 8'hFF);
    tick();
    check("restart_an", bus.an, 8'hF7);

    // Leading-zero suppression keeps the anode driven.
    bus.digits = 24'h023456;
    bus.count  = 3'd5;
    ticks(6);
    check("lz_seg", bus.seg, 7'h7F);
    check("lz_an", bus.an, 8'hDF);

    // Out-of-range BCD shows a dash.
    bus.digits = 24'h02345C;
    bus.count  = 3'd0;
    ticks(6);
    check("dash_seg", bus.seg, 7'h3F);

    // Blink: one tick hides the digit, a second tick restores it.
    bus.blink_mask = 6'b000001;
    bus.blink_tick = 1'b1;
    tick();
    bus.blink_tick = 1'b0;
    tick();
    check("blink_off", bus.seg, 7'h7F);
    bus.blink_tick = 1'b1;
    tick();
    bus.blink_tick = 1'b0;
    tick();
    check("blink_on", bus.seg, 7'h3F);
    bus.blink_mask = 6'b0;

    // Colon dot on digit 2, none for select 6.
    bus.colon_en = 1'b1;
    bus.count    = 3'd2;
    ticks(6);
    check("colon_dp", bus.dp, 1'b0);
    bus.count = 3'd6;
    ticks(6);
    check("sel6_an", bus.an, 8'hFF);
    check("sel6_dp", bus.dp, 1'b1);

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bus.count = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) bus.digits = 24'($urandom);
      if ($urandom_range(0, 15) == 0) bus.blink_mask = 6'($urandom);
      if ($urandom_range(0, 15) == 0) bus.colon_en = 1'($urandom);
      bus.blink_tick = ($urandom_range(0, 7) == 0);
      tick();
    end
    bus.blink_tick = 1'b0;

    // Asynchronous reset in the middle of a blank window.
    bus.count = 3'd1;
    ticks(4);
    bus.count = 3'd4;
    ticks(2);
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_an", bus.an, 8'hFF);
    check("midrst_seg", bus.seg, 7'h7F);
    check("midrst_dp", bus.dp, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    ticks(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
